// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the controller state encoding
// used by both the master controller and the register slave.
package axi4lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // A timed-out transaction is reported with the DECERR code.
  localparam logic [1:0] RESP_TIMEOUT = RESP_DECERR;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WADDR = 3'd1,
    ST_WRESP = 3'd2,
    ST_RADDR = 3'd3,
    ST_RDATA = 3'd4,
    ST_RSP   = 3'd5
  } axi_state_e;

  // States in which a transaction is outstanding on the AXI side.
  function automatic logic is_busy(input axi_state_e s);
    return (s == ST_WADDR) || (s == ST_WRESP) || (s == ST_RADDR) || (s == ST_RDATA);
  endfunction

endpackage

// File: rtl/axi4lite_master_ctrl.sv
// Single-outstanding AXI4-Lite master: turns one command into an AW/W/B or AR/R
// sequence and returns one response, with a timeout against a silent slave.
module axi4lite_master_ctrl
  import axi4lite_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              arest,
  // command side
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  // response side
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  // AXI4-Lite write address / data / response
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  // AXI4-Lite read address / data
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  // controller state, for observation
  output axi_state_e        state
);

  // Every channel transfers on a rising edge where valid && ready; a raised valid
  // stays high with stable payload until that edge, except on timeout or reset.

  localparam int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  axi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]        rsp_resp_q, rsp_resp_d;
  logic              latch;
  logic              busy;
  logic              timeout_hit;

  assign busy        = is_busy(state_q);
  assign timeout_hit = (TIMEOUT != 0) && busy && (cnt_q == CNT_W'(TO_LAST));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    latch       = 1'b0;

    // Saturating: holds at TIMEOUT instead of wrapping.
    if (busy && (cnt_q != CNT_W'(TIMEOUT))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          latch     = 1'b1;
          cnt_d     = '0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cmd_write ? ST_WADDR : ST_RADDR;
        end
      end
      ST_WADDR: begin
        aw_done_d = aw_done_q | awready;
        w_done_d  = w_done_q | wready;
        if (timeout_hit) begin
          rsp_resp_d  = RESP_TIMEOUT;
          rsp_rdata_d = '0;
          state_d     = ST_RSP;
        end else if (aw_done_d && w_done_d) begin
          state_d = ST_WRESP;
        end
      end
      ST_WRESP: begin
        // A response arriving in the timeout cycle still wins.
        if (bvalid) begin
          rsp_resp_d  = bresp;
          rsp_rdata_d = '0;
          state_d     = ST_RSP;
        end else if (timeout_hit) begin
          rsp_resp_d  = RESP_TIMEOUT;
          rsp_rdata_d = '0;
          state_d     = ST_RSP;
        end
      end
      ST_RADDR: begin
        if (timeout_hit) begin
          rsp_resp_d  = RESP_TIMEOUT;
          rsp_rdata_d = '0;
          state_d     = ST_RSP;
        end else if (arready) begin
          state_d = ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (rvalid) begin
          rsp_resp_d  = rresp;
          rsp_rdata_d = rdata;
          state_d     = ST_RSP;
        end else if (timeout_hit) begin
          rsp_resp_d  = RESP_TIMEOUT;
          rsp_rdata_d = '0;
          state_d     = ST_RSP;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (arest) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= RESP_OKAY;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      if (latch) begin
        addr_q <= cmd_addr;
        data_q <= cmd_wdata;
      end
    end
  end

  // All outputs decode registered state only; IDLE keeps bready/rready high to drain stale responses.
  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RSP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign awvalid   = (state_q == ST_WADDR) && !aw_done_q;
  assign wvalid    = (state_q == ST_WADDR) && !w_done_q;
  assign bready    = (state_q == ST_IDLE) || (state_q == ST_WRESP);
  assign arvalid   = (state_q == ST_RADDR);
  assign rready    = (state_q == ST_IDLE) || (state_q == ST_RDATA);
  assign awaddr    = addr_q;
  assign araddr    = addr_q;
  assign wdata     = data_q;
  assign state     = state_q;

endmodule
